// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter among N_REQ one-byte holding slots, round-robin.
// Define TXARB_FIXED_PRIO_EN to select fixed priority (lowest pending index wins).
module uart_tx_arbiter #(
  parameter  int N_REQ  = 2,
  parameter  int DATA_W = 8,
  localparam int GW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        pending,
  output logic [N_REQ-1:0]        overrun,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [GW-1:0]           grant_id
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  logic [1:0]              state_q,   state_d;
  logic [N_REQ*DATA_W-1:0] slot_q,    slot_d;
  logic [N_REQ-1:0]        pending_q, pending_d;
  logic [N_REQ-1:0]        overrun_q, overrun_d;
  logic [DATA_W-1:0]       tx_data_q, tx_data_d;
  logic                    tx_start_q, tx_start_d;
  logic [GW-1:0]           grant_q,   grant_d;
  logic [GW-1:0]           last_q,    last_d;
  logic [GW-1:0]           start_s;
  logic [GW-1:0]           win_s;
  logic [N_REQ-1:0]        clear_s;

  // First set bit of pend, searching upward from start with wrap-around.
  function automatic logic [GW-1:0] pick_first(input logic [N_REQ-1:0] pend,
                                               input logic [GW-1:0]    start);
    logic [GW-1:0] win;
    logic [GW-1:0] idx;
    logic          found;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx   = GW'((int'(start) + k) % N_REQ);
      win   = (!found && pend[idx]) ? idx : win;
      found = found | pend[idx];
    end
    return win;
  endfunction

`ifdef TXARB_FIXED_PRIO_EN
  assign start_s = '0;
`else
  assign start_s = (last_q == GW'(N_REQ - 1)) ? '0 : last_q + GW'(1);
`endif

  assign win_s   = pick_first(pending_q, start_s);
  assign clear_s = (state_q == ST_ISSUE) ? (N_REQ'(1'b1) << grant_q) : '0;

  // Arbitration FSM: pick and load a winner in IDLE, pulse start in ISSUE, wait out the frame
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    last_d    = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          state_d   = ST_ISSUE;
          tx_data_d = slot_q[int'(win_s)*DATA_W +: DATA_W];
          grant_d   = win_s;
          last_d    = win_s;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (tx_busy) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    tx_start_d = (state_d == ST_ISSUE);
  end

  // Holding slots: a byte lands in an empty slot or one being issued this cycle, else it is dropped
  always_comb begin
    slot_d    = slot_q;
    pending_d = pending_q;
    overrun_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && (!pending_q[i] || clear_s[i])) begin
        slot_d[i*DATA_W +: DATA_W] = req_data[i*DATA_W +: DATA_W];
        pending_d[i]               = 1'b1;
      end else if (req_valid[i]) begin
        overrun_d[i] = 1'b1;
      end else if (clear_s[i]) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
  end

  // State registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      grant_q    <= '0;
      last_q     <= GW'(N_REQ - 1);
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
    end
  end

  assign pending  = pending_q;
  assign overrun  = overrun_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences,
// and randomized traffic checked against a timestamp-based reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  pending;
  logic [N-1:0]  overrun;
  logic [DW-1:0] tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic [0:0]    grant_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_valid(req_valid),
    .req_data (req_data),
    .pending  (pending),
    .overrun  (overrun),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .grant_id (grant_id)
  );

  typedef struct {
    int         rep;
    logic [1:0] rv;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       busy;
    logic [1:0] e_pend;
    logic [1:0] e_ovr;
    logic       e_start;
    logic [7:0] e_data;
    logic       e_gnt;
  } vec_t;

  vec_t tbl [$];

  // reference model state (values expected in the current cycle)
  logic [1:0] m_pend, m_ovr, n_pend, n_ovr;
  logic       m_start, n_start;
  logic [7:0] m_data, n_data;
  int         m_gnt, n_gnt, m_last, n_last;
  logic [7:0] m_byte [N];
  logic [7:0] acc_q [N][$];
  int         free_at, busy_lo, busy_hi;

  function automatic vec_t mk(int rep, logic [1:0] rv, logic [7:0] d0, logic [7:0] d1,
                              logic busy, logic [1:0] ep, logic [1:0] eo, logic es,
                              logic [7:0] ed, logic eg);
    vec_t v;
    v.rep = rep; v.rv = rv; v.d0 = d0; v.d1 = d1; v.busy = busy;
    v.e_pend = ep; v.e_ovr = eo; v.e_start = es; v.e_data = ed; v.e_gnt = eg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // drive one cycle of inputs, then move to the next sampling point
  task automatic step(input logic [1:0] rv, input logic [7:0] d0, input logic [7:0] d1,
                      input logic busy);
    req_valid = rv;
    req_data  = {d1, d0};
    tx_busy   = busy;
    @(negedge clk);
  endtask

  // winner under the arbitration rule: first pending index after the previous grant
  function automatic int pick(input logic [1:0] pend, input int last);
    int idx;
`ifdef TXARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) begin
      idx = k;
      if (pend[idx]) return idx;
    end
`else
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (pend[idx]) return idx;
    end
`endif
    return 0;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] cur0, cur1, nb;
    logic [1:0] rv;
    logic [15:0] dd;
    logic       busy;
    int         exp_src, found, w, len;

    rstn = 1'b0; req_valid = '0; req_data = '0; tx_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // single request and simultaneous pair, one record per cycle (repeat count first)
    tbl.push_back(mk(1,  2'b11, 8'h11, 8'h22, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mk(1,  2'b00, 8'h00, 8'h00, 1'b0, 2'b11, 2'b00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mk(1,  2'b00, 8'h00, 8'h00, 1'b0, 2'b11, 2'b00, 1'b1, 8'h11, 1'b0));
    tbl.push_back(mk(3,  2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 2'b00, 1'b0, 8'h11, 1'b0));
    tbl.push_back(mk(2,  2'b00, 8'h00, 8'h00, 1'b0, 2'b10, 2'b00, 1'b0, 8'h11, 1'b0));
    tbl.push_back(mk(1,  2'b00, 8'h00, 8'h00, 1'b0, 2'b10, 2'b00, 1'b1, 8'h22, 1'b1));
    tbl.push_back(mk(2,  2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h22, 1'b1));
    tbl.push_back(mk(1,  2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h22, 1'b1));
    tbl.push_back(mk(1,  2'b01, 8'h5A, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h22, 1'b1));
    tbl.push_back(mk(1,  2'b00, 8'h00, 8'h00, 1'b0, 2'b01, 2'b00, 1'b0, 8'h22, 1'b1));
    tbl.push_back(mk(1,  2'b00, 8'h00, 8'h00, 1'b0, 2'b01, 2'b00, 1'b1, 8'h5A, 1'b0));
    tbl.push_back(mk(10, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h5A, 1'b0));
    tbl.push_back(mk(4,  2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h5A, 1'b0));

    foreach (tbl[j]) begin
      for (int r = 0; r < tbl[j].rep; r++) begin
        chk($sformatf("tbl%0d_pending", j),  32'(pending),  32'(tbl[j].e_pend));
        chk($sformatf("tbl%0d_overrun", j),  32'(overrun),  32'(tbl[j].e_ovr));
        chk($sformatf("tbl%0d_tx_start", j), 32'(tx_start), 32'(tbl[j].e_start));
        chk($sformatf("tbl%0d_tx_data", j),  32'(tx_data),  32'(tbl[j].e_data));
        chk($sformatf("tbl%0d_grant_id", j), 32'(grant_id), 32'(tbl[j].e_gnt));
        step(tbl[j].rv, tbl[j].d0, tbl[j].d1, tbl[j].busy);
      end
    end

    // overrun: second strobe on a full slot is dropped and flagged once
    step(2'b01, 8'hA0, 8'h00, 1'b0);
    step(2'b00, 8'h00, 8'h00, 1'b0);
    chk("ovr_prep_start", 32'(tx_start), 32'd1);
    step(2'b00, 8'h00, 8'h00, 1'b0);
    step(2'b10, 8'h00, 8'h33, 1'b1);
    chk("ovr_pending", 32'(pending), 32'h2);
    chk("ovr_no_early_pulse", 32'(overrun), 32'h0);
    step(2'b10, 8'h00, 8'h44, 1'b1);
    chk("ovr_pulse", 32'(overrun), 32'h2);
    step(2'b00, 8'h00, 8'h00, 1'b1);
    chk("ovr_single_pulse", 32'(overrun), 32'h0);
    step(2'b00, 8'h00, 8'h00, 1'b0);
    step(2'b00, 8'h00, 8'h00, 1'b0);
    chk("ovr_start", 32'(tx_start), 32'd1);
    chk("ovr_data_first_byte", 32'(tx_data), 32'h33);
    chk("ovr_grant", 32'(grant_id), 32'd1);
    step(2'b00, 8'h00, 8'h00, 1'b0);
    step(2'b00, 8'h00, 8'h00, 1'b1);
    step(2'b00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("ovr_dropped_never_sent", 32'(tx_start), 32'd0);
      chk("ovr_slot_empty", 32'(pending), 32'h0);
      step(2'b00, 8'h00, 8'h00, 1'b0);
    end

    // capture-on-clear: a new byte in the ISSUE cycle is kept, no overrun
    step(2'b01, 8'h66, 8'h00, 1'b0);
    step(2'b00, 8'h00, 8'h00, 1'b0);
    chk("coc_start1", 32'(tx_start), 32'd1);
    chk("coc_data1", 32'(tx_data), 32'h66);
    chk("coc_grant1", 32'(grant_id), 32'd0);
    step(2'b01, 8'h77, 8'h00, 1'b0);
    chk("coc_no_overrun", 32'(overrun), 32'h0);
    chk("coc_pending", 32'(pending), 32'h1);
    step(2'b00, 8'h00, 8'h00, 1'b1);
    step(2'b00, 8'h00, 8'h00, 1'b0);
    step(2'b00, 8'h00, 8'h00, 1'b0);
    chk("coc_start2", 32'(tx_start), 32'd1);
    chk("coc_data2", 32'(tx_data), 32'h77);
    step(2'b00, 8'h00, 8'h00, 1'b0);
    chk("coc_drained", 32'(pending), 32'h0);
    step(2'b00, 8'h00, 8'h00, 1'b1);
    step(2'b00, 8'h00, 8'h00, 1'b0);

    // reset mid-frame with both slots full
    step(2'b11, 8'hC1, 8'hC2, 1'b0);
    step(2'b00, 8'h00, 8'h00, 1'b0);
    step(2'b00, 8'h00, 8'h00, 1'b0);
    step(2'b11, 8'hD1, 8'hD2, 1'b1);
    chk("rst_both_full", 32'(pending), 32'h3);
    rstn = 1'b0;
    step(2'b00, 8'h00, 8'h00, 1'b1);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    rstn = 1'b1;
    step(2'b10, 8'h00, 8'hB5, 1'b0);
    chk("rst_new_pending", 32'(pending), 32'h2);
    step(2'b00, 8'h00, 8'h00, 1'b0);
    chk("rst_new_start", 32'(tx_start), 32'd1);
    chk("rst_new_grant", 32'(grant_id), 32'd1);
    chk("rst_new_data", 32'(tx_data), 32'hB5);
    step(2'b00, 8'h00, 8'h00, 1'b0);
    step(2'b00, 8'h00, 8'h00, 1'b1);
    step(2'b00, 8'h00, 8'h00, 1'b0);

    // fairness with refill on every grant
    cur0 = 8'h11;
    cur1 = 8'h22;
    step(2'b11, 8'h11, 8'h22, 1'b0);
    for (int g = 0; g < 4; g++) begin
`ifdef TXARB_FIXED_PRIO_EN
      exp_src = 0;
`else
      exp_src = g % 2;
`endif
      found = 0;
      for (w = 0; w < 8 && found == 0; w++) begin
        if (tx_start) found = 1;
        else step(2'b00, 8'h00, 8'h00, 1'b0);
      end
      chk("fair_start_seen", 32'(found), 32'd1);
      chk("fair_grant", 32'(grant_id), 32'(exp_src));
      chk("fair_data", 32'(tx_data), (exp_src == 1) ? 32'(cur1) : 32'(cur0));
      nb = 8'h40 + 8'(g);
      if (exp_src == 1) begin
        cur1 = nb;
        step(2'b10, 8'h00, nb, 1'b0);
      end else begin
        cur0 = nb;
        step(2'b01, nb, 8'h00, 1'b0);
      end
      step(2'b00, 8'h00, 8'h00, 1'b1);
      step(2'b00, 8'h00, 8'h00, 1'b0);
    end

    // randomized traffic against the reference model
    rstn = 1'b0;
    step(2'b00, 8'h00, 8'h00, 1'b0);
    rstn = 1'b1;
    m_pend = '0; m_ovr = '0; m_start = 1'b0; m_data = '0; m_gnt = 0; m_last = N - 1;
    for (int i = 0; i < N; i++) begin
      m_byte[i] = '0;
      acc_q[i].delete();
    end
    free_at = 0; busy_lo = 1; busy_hi = 0;
    for (int kc = 0; kc < 800; kc++) begin
      chk("rnd_pending", 32'(pending), 32'(m_pend));
      chk("rnd_overrun", 32'(overrun), 32'(m_ovr));
      chk("rnd_tx_start", 32'(tx_start), 32'(m_start));
      chk("rnd_tx_data", 32'(tx_data), 32'(m_data));
      chk("rnd_grant", 32'(grant_id), 32'(m_gnt));
      if (tx_start) begin
        chk("rnd_sb_byte_available", 32'(acc_q[grant_id].size() > 0), 32'd1);
        if (acc_q[grant_id].size() > 0) begin
          chk("rnd_sb_order", 32'(tx_data), 32'(acc_q[grant_id].pop_front()));
        end
      end
      rv[0] = ($urandom_range(0, 3) == 0);
      rv[1] = ($urandom_range(0, 3) == 0);
      dd    = 16'($urandom);
      busy  = (kc >= busy_lo) && (kc <= busy_hi);
      n_start = 1'b0; n_data = m_data; n_gnt = m_gnt; n_last = m_last;
      if (kc >= free_at && m_pend != 2'b00) begin
        w       = pick(m_pend, m_last);
        n_start = 1'b1;
        n_data  = m_byte[w];
        n_gnt   = w;
        n_last  = w;
        len     = $urandom_range(1, 5);
        busy_lo = kc + 2;
        busy_hi = kc + 1 + len;
        free_at = kc + len + 3;
      end
      n_pend = m_pend;
      n_ovr  = '0;
      for (int i = 0; i < N; i++) begin
        if (rv[i] && (!m_pend[i] || (m_start && m_gnt == i))) begin
          m_byte[i] = dd[i*8 +: 8];
          n_pend[i] = 1'b1;
          acc_q[i].push_back(dd[i*8 +: 8]);
        end else if (rv[i]) begin
          n_ovr[i] = 1'b1;
        end else if (m_start && m_gnt == i) begin
          n_pend[i] = 1'b0;
        end
      end
      step(rv, dd[7:0], dd[15:8], busy);
      m_pend = n_pend; m_ovr = n_ovr; m_start = n_start;
      m_data = n_data; m_gnt = n_gnt; m_last = n_last;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
